pwm_wb_regs: RTL and testbench

- Wishbone classic slave register bank that sits directly upstream of pwm_core.
- Drives pwm_core's control inputs: pwm_core_EN, main_counter_EN, o_pwm_EN, duty_sel, period_reg and duty_reg.
- PERIOD/DUTY writes land in staging registers. They transfer to the live outputs only at a PWM period boundary, so no glitched cycles reach o_pwm.
- Also enforces duty <= period and reports status to the bus master.

---
 rtl/pwm_wb_regs.sv | 135 +++++++++++++
 tb/tb_pwm_wb_regs.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_wb_regs.sv
// Wishbone classic register bank feeding pwm_core. PERIOD/DUTY are staged and
// copied to the live outputs only at a period boundary, so o_pwm never glitches.
module pwm_wb_regs #(
    parameter int DW         = 16,
    parameter int RST_PERIOD = 100,
    parameter int RST_DUTY   = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [3:0]    wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack_o,
    input  logic          period_end,
    output logic          pwm_core_EN,
    output logic          main_counter_EN,
    output logic          o_pwm_EN,
    output logic          duty_sel,
    output logic [DW-1:0] period_reg,
    output logic [DW-1:0] duty_reg,
    output logic          irq
);
    typedef enum logic {IDLE, ACK} state_t;

    state_t        state, state_nxt;
    logic          irq_en, pending, duty_clamped;
    logic [DW-1:0] period_stg, duty_stg, period_nxt, duty_nxt, rdata;
    logic          access, wr_ctrl, wr_period, wr_duty, wr_status;
    logic          force_upd, clamp_set, xfer;
    logic          unused_adr;

    assign unused_adr = &{1'b0, wb_adr_i[1:0]};

    assign access    = (state == IDLE) && wb_cyc_i && wb_stb_i;
    assign wr_ctrl   = access && wb_we_i && (wb_adr_i[3:2] == 2'd0);
    assign wr_period = access && wb_we_i && (wb_adr_i[3:2] == 2'd1);
    assign wr_duty   = access && wb_we_i && (wb_adr_i[3:2] == 2'd2);
    assign wr_status = access && wb_we_i && (wb_adr_i[3:2] == 2'd3);
    assign force_upd = wr_ctrl && wb_dat_i[4];

    // Transfer looks at the pending flag before this edge; a staging write in
    // the same cycle rides along because live takes the post-write values.
    assign xfer = force_upd || (pending && (period_end || !main_counter_EN));

    assign wb_ack_o = (state == ACK);
    assign irq      = duty_clamped && irq_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wb_cyc_i && wb_stb_i) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Clamp to duty <= period inside the write cycle itself.
    always_comb begin
        period_nxt = period_stg;
        duty_nxt   = duty_stg;
        clamp_set  = 1'b0;
        if (wr_period) begin
            period_nxt = wb_dat_i;
            if (wb_dat_i < duty_stg) begin
                duty_nxt  = wb_dat_i;
                clamp_set = 1'b1;
            end
        end
        if (wr_duty) begin
            if (wb_dat_i > period_stg) begin
                duty_nxt  = period_stg;
                clamp_set = 1'b1;
            end else begin
                duty_nxt = wb_dat_i;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (wb_adr_i[3:2])
            2'd0: rdata[5:0] = {irq_en, 1'b0, duty_sel, o_pwm_EN, main_counter_EN, pwm_core_EN};
            2'd1: rdata = period_stg;
            2'd2: rdata = duty_stg;
            2'd3: rdata[1:0] = {duty_clamped, pending};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_dat_o        <= '0;
            pwm_core_EN     <= 1'b0;
            main_counter_EN <= 1'b0;
            o_pwm_EN        <= 1'b0;
            duty_sel        <= 1'b0;
            irq_en          <= 1'b0;
            pending         <= 1'b0;
            duty_clamped    <= 1'b0;
            period_stg      <= DW'(RST_PERIOD);
            duty_stg        <= DW'(RST_DUTY);
            period_reg      <= DW'(RST_PERIOD);
            duty_reg        <= DW'(RST_DUTY);
        end else begin
            wb_dat_o <= (access && !wb_we_i) ? rdata : '0;
            if (wr_ctrl) begin
                pwm_core_EN     <= wb_dat_i[0];
                main_counter_EN <= wb_dat_i[1];
                o_pwm_EN        <= wb_dat_i[2];
                duty_sel        <= wb_dat_i[3];
                irq_en          <= wb_dat_i[5];
            end
            period_stg <= period_nxt;
            duty_stg   <= duty_nxt;
            if (xfer) begin
                period_reg <= period_nxt;
                duty_reg   <= duty_nxt;
                pending    <= 1'b0;
            end else if (wr_period || wr_duty) begin
                pending <= 1'b1;
            end
            // A fresh clamp beats a simultaneous W1C.
            if (clamp_set)                      duty_clamped <= 1'b1;
            else if (wr_status && wb_dat_i[1]) duty_clamped <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pwm_wb_regs.sv
// Bench for pwm_wb_regs: directed vector table, reset-in-ack sequence, and
// randomized traffic compared against a rule-level reference model.
module tb_pwm_wb_regs;
    localparam int KW = 0, KR = 1, KI = 2;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, period_end = 1'b0;
    logic [3:0]  adr = '0;
    logic [15:0] dat_w = '0;
    logic [15:0] wb_dat_o, period_reg, duty_reg;
    logic        wb_ack_o, pwm_core_EN, main_counter_EN, o_pwm_EN, duty_sel, irq;

    int checks = 0, errors = 0;

    pwm_wb_regs #(.DW(16), .RST_PERIOD(100), .RST_DUTY(0)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dat_w),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .period_end(period_end),
        .pwm_core_EN(pwm_core_EN), .main_counter_EN(main_counter_EN), .o_pwm_EN(o_pwm_EN),
        .duty_sel(duty_sel), .period_reg(period_reg), .duty_reg(duty_reg), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: register-map rules applied once per clock edge.
    logic [5:0]  m_ctrl;
    logic [15:0] m_sper, m_sduty, m_lper, m_lduty, m_rd;
    bit          m_pend, m_clamp, m_ack;

    task automatic m_reset();
        m_ctrl = '0; m_sper = 16'd100; m_sduty = 16'd0; m_lper = 16'd100; m_lduty = 16'd0;
        m_rd = '0; m_pend = 0; m_clamp = 0; m_ack = 0;
    endtask

    task automatic m_step();
        bit acc, upd, staged_wr, set_c, clr_c;
        logic [15:0] np, nd;
        logic [5:0]  nc;
        acc = !m_ack && cyc && stb;
        np = m_sper; nd = m_sduty; nc = m_ctrl;
        upd = 0; staged_wr = 0; set_c = 0; clr_c = 0;
        m_rd = '0;
        if (acc && !we) begin
            if (adr[3:2] == 2'd0)      m_rd = {10'd0, m_ctrl};
            else if (adr[3:2] == 2'd1) m_rd = m_sper;
            else if (adr[3:2] == 2'd2) m_rd = m_sduty;
            else                       m_rd = {14'd0, m_clamp, m_pend};
        end
        if (acc && we) begin
            if (adr[3:2] == 2'd0) begin
                nc = dat_w[5:0] & 6'b101111;
                upd = dat_w[4];
            end else if (adr[3:2] == 2'd1) begin
                np = dat_w; staged_wr = 1;
                set_c = dat_w < m_sduty;
                nd = set_c ? dat_w : m_sduty;
            end else if (adr[3:2] == 2'd2) begin
                staged_wr = 1;
                set_c = dat_w > m_sper;
                nd = set_c ? m_sper : dat_w;
            end else begin
                clr_c = dat_w[1];
            end
        end
        if (upd || (m_pend && (period_end || !m_ctrl[1]))) begin
            m_lper = np; m_lduty = nd; m_pend = 0;
        end else begin
            m_pend = m_pend || staged_wr;
        end
        m_clamp = set_c || (m_clamp && !clr_c);
        m_sper = np; m_sduty = nd; m_ctrl = nc; m_ack = acc;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else     m_step();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One access: stb for one edge, ack must follow exactly one cycle later.
    task automatic bus(input bit wr, input logic [3:0] a, input logic [15:0] d,
                       input bit pe1, input bit pe2,
                       output logic [15:0] rd, output logic [15:0] mrd);
        @(negedge clk);
        cyc = 1; stb = 1; we = wr; adr = a; dat_w = d; period_end = pe1;
        check("ack_before", wb_ack_o, 0);
        @(negedge clk);
        check("ack_high", wb_ack_o, 1);
        rd = wb_dat_o; mrd = m_rd;
        cyc = 0; stb = 0; we = 0; period_end = pe2;
        @(negedge clk);
        check("ack_single", wb_ack_o, 0);
        check("dat_idle", wb_dat_o, 0);
        period_end = 0;
    endtask

    task automatic idle(input bit pe);
        @(negedge clk); period_end = pe;
        @(negedge clk); period_end = 0;
    endtask

    typedef struct {
        int          kind;
        logic [3:0]  adr;
        logic [15:0] dat;
        bit          pe;
        logic [15:0] rd;
        logic [15:0] per;
        logic [15:0] duty;
        logic [3:0]  en;
        bit          irq;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [15:0] rd, mrd;
        // kind adr dat pe | rd per duty en irq   (expected after the step)
        tbl.push_back('{KR, 4'h0, 16'h0,  0, 16'h0,  16'd100, 16'd0,   4'h0, 0});
        tbl.push_back('{KR, 4'h4, 16'h0,  0, 16'd100,16'd100, 16'd0,   4'h0, 0});
        tbl.push_back('{KR, 4'h8, 16'h0,  0, 16'd0,  16'd100, 16'd0,   4'h0, 0});
        tbl.push_back('{KR, 4'hC, 16'h0,  0, 16'h0,  16'd100, 16'd0,   4'h0, 0});
        tbl.push_back('{KW, 4'h0, 16'h7,  0, 16'h0,  16'd100, 16'd0,   4'h7, 0});
        tbl.push_back('{KW, 4'h8, 16'd25, 0, 16'h0,  16'd100, 16'd0,   4'h7, 0});
        tbl.push_back('{KR, 4'hC, 16'h0,  0, 16'h1,  16'd100, 16'd0,   4'h7, 0});
        tbl.push_back('{KI, 4'h0, 16'h0,  1, 16'h0,  16'd100, 16'd25,  4'h7, 0});
        tbl.push_back('{KR, 4'hC, 16'h0,  0, 16'h0,  16'd100, 16'd25,  4'h7, 0});
        tbl.push_back('{KW, 4'h4, 16'd200,0, 16'h0,  16'd100, 16'd25,  4'h7, 0});
        tbl.push_back('{KW, 4'h8, 16'd100,0, 16'h0,  16'd100, 16'd25,  4'h7, 0});
        tbl.push_back('{KI, 4'h0, 16'h0,  0, 16'h0,  16'd100, 16'd25,  4'h7, 0});
        tbl.push_back('{KI, 4'h0, 16'h0,  1, 16'h0,  16'd200, 16'd100, 4'h7, 0});
        tbl.push_back('{KW, 4'h8, 16'd250,0, 16'h0,  16'd200, 16'd100, 4'h7, 0});
        tbl.push_back('{KR, 4'h8, 16'h0,  0, 16'd200,16'd200, 16'd100, 4'h7, 0});
        tbl.push_back('{KR, 4'hC, 16'h0,  0, 16'h3,  16'd200, 16'd100, 4'h7, 0});
        tbl.push_back('{KW, 4'h0, 16'h27, 0, 16'h0,  16'd200, 16'd100, 4'h7, 1});
        tbl.push_back('{KW, 4'hC, 16'h2,  0, 16'h0,  16'd200, 16'd100, 4'h7, 0});
        tbl.push_back('{KR, 4'hC, 16'h0,  0, 16'h1,  16'd200, 16'd100, 4'h7, 0});
        tbl.push_back('{KI, 4'h0, 16'h0,  1, 16'h0,  16'd200, 16'd200, 4'h7, 0});
        tbl.push_back('{KW, 4'h0, 16'h5,  0, 16'h0,  16'd200, 16'd200, 4'h5, 0});
        tbl.push_back('{KW, 4'h4, 16'd20, 0, 16'h0,  16'd20,  16'd20,  4'h5, 0});
        tbl.push_back('{KR, 4'hC, 16'h0,  0, 16'h2,  16'd20,  16'd20,  4'h5, 0});
        tbl.push_back('{KW, 4'hC, 16'h2,  0, 16'h0,  16'd20,  16'd20,  4'h5, 0});
        tbl.push_back('{KW, 4'h0, 16'h7,  0, 16'h0,  16'd20,  16'd20,  4'h7, 0});
        tbl.push_back('{KW, 4'h8, 16'd15, 0, 16'h0,  16'd20,  16'd20,  4'h7, 0});
        tbl.push_back('{KW, 4'h0, 16'h17, 0, 16'h0,  16'd20,  16'd15,  4'h7, 0});
        tbl.push_back('{KR, 4'h0, 16'h0,  0, 16'h7,  16'd20,  16'd15,  4'h7, 0});
        tbl.push_back('{KR, 4'hC, 16'h0,  0, 16'h0,  16'd20,  16'd15,  4'h7, 0});
        tbl.push_back('{KW, 4'h4, 16'd0,  0, 16'h0,  16'd20,  16'd15,  4'h7, 0});
        tbl.push_back('{KR, 4'h8, 16'h0,  0, 16'd0,  16'd20,  16'd15,  4'h7, 0});
        tbl.push_back('{KR, 4'hC, 16'h0,  0, 16'h3,  16'd20,  16'd15,  4'h7, 0});
        tbl.push_back('{KW, 4'h0, 16'h10, 0, 16'h0,  16'd0,   16'd0,   4'h0, 0});
        tbl.push_back('{KR, 4'hC, 16'h0,  0, 16'h2,  16'd0,   16'd0,   4'h0, 0});
        tbl.push_back('{KW, 4'h0, 16'h08, 0, 16'h0,  16'd0,   16'd0,   4'h8, 0});

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ack", wb_ack_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_per", period_reg, 100);
        check("rst_duty", duty_reg, 0);
        check("rst_en", {duty_sel, o_pwm_EN, main_counter_EN, pwm_core_EN}, 0);
        check("rst_irq", irq, 0);
        rst = 0;

        foreach (tbl[i]) begin
            if (tbl[i].kind == KI) idle(tbl[i].pe);
            else bus(tbl[i].kind == KW, tbl[i].adr, tbl[i].dat, tbl[i].pe, 0, rd, mrd);
            if (tbl[i].kind == KR) check($sformatf("v%0d_rd", i), rd, tbl[i].rd);
            check($sformatf("v%0d_per", i), period_reg, tbl[i].per);
            check($sformatf("v%0d_duty", i), duty_reg, tbl[i].duty);
            check($sformatf("v%0d_en", i), {duty_sel, o_pwm_EN, main_counter_EN, pwm_core_EN}, tbl[i].en);
            check($sformatf("v%0d_irq", i), irq, tbl[i].irq);
        end

        // Reset while ack is high on a PERIOD write
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = 4'h4; dat_w = 16'd50;
        @(negedge clk);
        check("mid_ack_high", wb_ack_o, 1);
        rst = 1;
        #1;
        check("mid_ack_drop", wb_ack_o, 0);
        check("mid_dat", wb_dat_o, 0);
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);
        rst = 0;
        bus(0, 4'h4, 16'h0, 0, 0, rd, mrd);
        check("mid_period_rd", rd, 100);
        check("mid_period_live", period_reg, 100);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [1:0]  sel;
            logic [15:0] d;
            bit          wr;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                idle($urandom_range(0, 3) == 0);
            end else begin
                sel = 2'($urandom_range(0, 3));
                wr  = $urandom_range(0, 1) == 1;
                if (sel == 2'd1 || sel == 2'd2) d = 16'($urandom_range(0, 260));
                else                            d = 16'($urandom);
                bus(wr, {sel, 2'($urandom)}, d, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, rd, mrd);
                if (!wr) check($sformatf("r%0d_rd", n), rd, mrd);
            end
            check($sformatf("r%0d_per", n), period_reg, m_lper);
            check($sformatf("r%0d_duty", n), duty_reg, m_lduty);
            check($sformatf("r%0d_en", n), {duty_sel, o_pwm_EN, main_counter_EN, pwm_core_EN}, m_ctrl[3:0]);
            check($sformatf("r%0d_irq", n), irq, m_clamp && m_ctrl[5]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
